// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - Y86-64 encodings, E-register/CC types and condition evaluation
// Contents:
//   icodes, ALU function enum, condition (ifun) codes, stat codes, RESP/RNONE,
//   cc_t {zf,sf,of}, e_reg_t (E pipeline register), bubble/reset constants,
//   cond_eval() for jXX/cmovXX.
package execute_stage_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALUADD = 2'd0,
        ALUSUB = 2'd1,
        ALUAND = 2'd2,
        ALUXOR = 2'd3
    } alu_fn_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SADR = 4'h2;
    localparam logic [3:0] SINS = 4'h3;
    localparam logic [3:0] SHLT = 4'h4;

    localparam logic [3:0] RESP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] val_c;
        logic [63:0] val_a;
        logic [63:0] val_b;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        val_c: 64'h0,
        val_a: 64'h0,
        val_b: 64'h0,
        dst_e: RNONE,
        dst_m: RNONE,
        src_a: RNONE,
        src_b: RNONE
    };

    function automatic logic cond_eval(input logic [3:0] fn, input cc_t cc);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (fn)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = lt | cc.zf;
            C_L:     cond_eval = lt;
            C_E:     cond_eval = cc.zf;
            C_NE:    cond_eval = ~cc.zf;
            C_GE:    cond_eval = ~lt;
            C_G:     cond_eval = ~lt & ~cc.zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational 64-bit Y86-64 ALU with ZF/SF/OF generation
// Ports:
//   alu_a, alu_b [63:0] in  : operands (result is B op A)
//   alu_fn              in  : ADD/SUB/AND/XOR
//   result [63:0]       out : wrap-around result, carry discarded
//   flags               out : {zf, sf, of} derived from result
module exec_alu
    import execute_stage_pkg::*;
(
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  alu_fn_e     alu_fn,
    output logic [63:0] result,
    output cc_t         flags
);

    always_comb begin
        result   = 64'h0;
        flags.of = 1'b0;
        case (alu_fn)
            ALUADD: begin
                result   = alu_b + alu_a;
                flags.of = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
            end
            ALUSUB: begin
                result   = alu_b - alu_a;
                flags.of = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
            end
            ALUAND: result = alu_b & alu_a;
            ALUXOR: result = alu_b ^ alu_a;
            default: result = 64'h0;
        endcase
        flags.zf = (result == 64'h0);
        flags.sf = result[63];
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: E register, ALU, CC register, cond evaluation
// Optional feature macro: EXEC_EXC_CC_GATE_EN (CC writes also require m_stat_i and W_stat_i == SAOK)
// Ports:
//   clk_i, rst_n_i (async, active-low), E_bubble_i
//   d_stat_i/d_icode_i/d_ifun_i, d_valC_i/d_valA_i/d_valB_i, d_dstE_i/d_dstM_i/d_srcA_i/d_srcB_i : decode outputs
//   m_stat_i, W_stat_i : downstream status for CC gating
//   e_valE_o, e_dstE_o, e_cnd_o : combinational results of the instruction in E
//   E_stat_o, E_icode_o, E_valA_o, E_dstM_o, E_srcA_o, E_srcB_o : registered E fields
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        E_bubble_i,
    input  logic [3:0]  d_stat_i,
    input  logic [3:0]  d_icode_i,
    input  logic [3:0]  d_ifun_i,
    input  logic [63:0] d_valC_i,
    input  logic [63:0] d_valA_i,
    input  logic [63:0] d_valB_i,
    input  logic [3:0]  d_dstE_i,
    input  logic [3:0]  d_dstM_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    input  logic [3:0]  m_stat_i,
    input  logic [3:0]  W_stat_i,
    output logic [63:0] e_valE_o,
    output logic [3:0]  e_dstE_o,
    output logic        e_cnd_o,
    output logic [3:0]  E_stat_o,
    output logic [3:0]  E_icode_o,
    output logic [3:0]  E_dstM_o,
    output logic [3:0]  E_srcA_o,
    output logic [3:0]  E_srcB_o,
    output logic [63:0] E_valA_o
);

    e_reg_t      e_q;
    e_reg_t      d_in;
    cc_t         cc_q;
    cc_t         alu_flags;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    alu_fn_e     alu_fn;
    logic        set_cc;

    always_comb begin
        d_in = '{
            stat:  d_stat_i,
            icode: d_icode_i,
            ifun:  d_ifun_i,
            val_c: d_valC_i,
            val_a: d_valA_i,
            val_b: d_valB_i,
            dst_e: d_dstE_i,
            dst_m: d_dstM_i,
            src_a: d_srcA_i,
            src_b: d_srcB_i
        };
    end

    // Bubble wins over a normal load.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e_q <= E_BUBBLE;
        end else if (E_bubble_i) begin
            e_q <= E_BUBBLE;
        end else begin
            e_q <= d_in;
        end
    end

    always_comb begin
        alu_a = 64'h0;
        case (e_q.icode)
            IRRMOVQ, IOPQ:             alu_a = e_q.val_a;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = e_q.val_c;
            ICALL, IPUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            IRET, IPOPQ:               alu_a = 64'h0000_0000_0000_0008;
            default:                   alu_a = 64'h0;
        endcase
    end

    always_comb begin
        alu_b = 64'h0;
        case (e_q.icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: alu_b = e_q.val_b;
            default:                                            alu_b = 64'h0;
        endcase
    end

    // Undefined OPQ function codes fall back to ADD.
    always_comb begin
        alu_fn = ALUADD;
        if (e_q.icode == IOPQ) begin
            case (e_q.ifun)
                4'h1:    alu_fn = ALUSUB;
                4'h2:    alu_fn = ALUAND;
                4'h3:    alu_fn = ALUXOR;
                default: alu_fn = ALUADD;
            endcase
        end
    end

    exec_alu u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_fn (alu_fn),
        .result (alu_result),
        .flags  (alu_flags)
    );

`ifdef EXEC_EXC_CC_GATE_EN
    // A faulting instruction further down the pipe freezes the flags so
    // younger instructions cannot leave architecturally visible state behind.
    assign set_cc = (e_q.icode == IOPQ) && (m_stat_i == SAOK) && (W_stat_i == SAOK);
`else
    logic unused_stat;
    assign unused_stat = ^{m_stat_i, W_stat_i};
    assign set_cc = (e_q.icode == IOPQ);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cc_q <= CC_RESET;
        end else if (set_cc) begin
            cc_q <= alu_flags;
        end
    end

    // Condition uses the registered CC, never the flags being produced this cycle.
    assign e_cnd_o  = cond_eval(e_q.ifun, cc_q);
    assign e_valE_o = alu_result;
    assign e_dstE_o = ((e_q.icode == IRRMOVQ) && !e_cnd_o) ? RNONE : e_q.dst_e;

    assign E_stat_o  = e_q.stat;
    assign E_icode_o = e_q.icode;
    assign E_valA_o  = e_q.val_a;
    assign E_dstM_o  = e_q.dst_m;
    assign E_srcA_o  = e_q.src_a;
    assign E_srcB_o  = e_q.src_b;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard testbench for execute_stage
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        E_bubble_i;
    logic [3:0]  d_stat_i, d_icode_i, d_ifun_i;
    logic [63:0] d_valC_i, d_valA_i, d_valB_i;
    logic [3:0]  d_dstE_i, d_dstM_i, d_srcA_i, d_srcB_i;
    logic [3:0]  m_stat_i, W_stat_i;
    logic [63:0] e_valE_o;
    logic [3:0]  e_dstE_o;
    logic        e_cnd_o;
    logic [3:0]  E_stat_o, E_icode_o, E_dstM_o, E_srcA_o, E_srcB_o;
    logic [63:0] E_valA_o;

    execute_stage dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .E_bubble_i (E_bubble_i),
        .d_stat_i   (d_stat_i),
        .d_icode_i  (d_icode_i),
        .d_ifun_i   (d_ifun_i),
        .d_valC_i   (d_valC_i),
        .d_valA_i   (d_valA_i),
        .d_valB_i   (d_valB_i),
        .d_dstE_i   (d_dstE_i),
        .d_dstM_i   (d_dstM_i),
        .d_srcA_i   (d_srcA_i),
        .d_srcB_i   (d_srcB_i),
        .m_stat_i   (m_stat_i),
        .W_stat_i   (W_stat_i),
        .e_valE_o   (e_valE_o),
        .e_dstE_o   (e_dstE_o),
        .e_cnd_o    (e_cnd_o),
        .E_stat_o   (E_stat_o),
        .E_icode_o  (E_icode_o),
        .E_dstM_o   (E_dstM_o),
        .E_srcA_o   (E_srcA_o),
        .E_srcB_o   (E_srcB_o),
        .E_valA_o   (E_valA_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] val_e;
        logic [3:0]  dst_e;
        logic        cnd;
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_a;
        logic [3:0]  dst_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    passed = 0;
    int    total = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valE"},  e_valE_o,  64'h0);
        chk({tag, ".dstE"},  e_dstE_o,  RNONE);
        chk({tag, ".cnd"},   e_cnd_o,   1'b1);
        chk({tag, ".stat"},  E_stat_o,  SAOK);
        chk({tag, ".icode"}, E_icode_o, INOP);
        chk({tag, ".valA"},  E_valA_o,  64'h0);
        chk({tag, ".dstM"},  E_dstM_o,  RNONE);
        chk({tag, ".srcA"},  E_srcA_o,  RNONE);
        chk({tag, ".srcB"},  E_srcB_o,  RNONE);
    endtask

    // Monitor: compare whatever is due this cycle against the DUT's E-stage view.
    always @(negedge clk_i) begin
        exp_t  e;
        string nm;
        if (rst_n_i) begin
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (int'(e.cyc) != cyc) begin
                    chk({nm, ".missed_cycle"}, cyc, e.cyc);
                end else begin
                    chk({nm, ".valE"},  e_valE_o,  e.val_e);
                    chk({nm, ".dstE"},  e_dstE_o,  e.dst_e);
                    chk({nm, ".cnd"},   e_cnd_o,   e.cnd);
                    chk({nm, ".stat"},  E_stat_o,  e.stat);
                    chk({nm, ".icode"}, E_icode_o, e.icode);
                    chk({nm, ".valA"},  E_valA_o,  e.val_a);
                    chk({nm, ".dstM"},  E_dstM_o,  e.dst_m);
                    chk({nm, ".srcA"},  E_srcA_o,  e.src_a);
                    chk({nm, ".srcB"},  E_srcB_o,  e.src_b);
                end
            end
        end
    end

    // Drive one decode-stage instruction at a falling edge; it is in E after the next
    // rising edge, so its expected response is due one cycle later. mst is the m_stat
    // seen by the CC write of the instruction currently leaving E.
    task automatic issue(input string nm, input logic bub,
                         input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [3:0] de,
                         input logic [63:0] xv, input logic [3:0] xd, input logic xc,
                         input logic [3:0] mst = SAOK);
        exp_t e;
        @(negedge clk_i);
        E_bubble_i = bub;
        m_stat_i   = mst;
        d_stat_i   = st;
        d_icode_i  = ic;
        d_ifun_i   = fn;
        d_valA_i   = va;
        d_valB_i   = vb;
        d_valC_i   = vc;
        d_dstE_i   = de;
        d_dstM_i   = RNONE;
        d_srcA_i   = (ic == INOP) ? RNONE : 4'h8;
        d_srcB_i   = (ic == INOP) ? RNONE : 4'h9;
        e.cyc   = 32'(cyc + 1);
        e.val_e = xv;
        e.dst_e = xd;
        e.cnd   = xc;
        e.stat  = bub ? SAOK  : st;
        e.icode = bub ? INOP  : ic;
        e.val_a = bub ? 64'h0 : va;
        e.dst_m = RNONE;
        e.src_a = bub ? RNONE : d_srcA_i;
        e.src_b = bub ? RNONE : d_srcB_i;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst_n_i = 1'b0;
        E_bubble_i = 1'b0;
        d_stat_i = SAOK; d_icode_i = INOP; d_ifun_i = 4'h0;
        d_valA_i = 64'h0; d_valB_i = 64'h0; d_valC_i = 64'h0;
        d_dstE_i = RNONE; d_dstM_i = RNONE; d_srcA_i = RNONE; d_srcB_i = RNONE;
        m_stat_i = SAOK; W_stat_i = SAOK;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("in_reset");
        rst_n_i = 1'b1;

        issue("nop",       0, SAOK, INOP,    4'h0, 64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);
        issue("je_rst",    0, SAOK, IJXX,    C_E,  64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);
        issue("jl_rst",    0, SAOK, IJXX,    C_L,  64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 0);
        issue("add_ovf",   0, SAOK, IOPQ,    4'h0, MAXP,   MAXP,  64'h0, 4'h3,  64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 1);
        issue("jle_ovf",   0, SAOK, IJXX,    C_LE, 64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 0);
        issue("jg_ovf",    0, SAOK, IJXX,    C_G,  64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);
        issue("sub_eq",    0, SAOK, IOPQ,    4'h1, 64'h5,  64'h5, 64'h0, 4'h3,  64'h0, 4'h3, 0);
        issue("jle_eq",    0, SAOK, IJXX,    C_LE, 64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);
        issue("add_neg",   0, SAOK, IOPQ,    4'h0, 64'h1,  64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 4'h5, ALL1, 4'h5, 1);
        issue("xor_b2b",   0, SAOK, IOPQ,    4'h3, 64'h3,  64'h3, 64'h0, 4'h6,  64'h0, 4'h6, 0);
        issue("cmovl_nt",  0, SAOK, IRRMOVQ, C_L,  64'h1234, 64'h999, 64'h0, 4'h2, 64'h1234, RNONE, 0);
        issue("sub_neg",   0, SAOK, IOPQ,    4'h1, 64'h1,  64'h0, 64'h0, 4'h5,  ALL1, 4'h5, 1);
        issue("cmovl_t",   0, SAOK, IRRMOVQ, C_L,  64'hABCD, 64'h999, 64'h0, 4'h2, 64'hABCD, 4'h2, 1);
        issue("sub_ovf",   0, SAOK, IOPQ,    4'h1, 64'h1,  64'h8000_0000_0000_0000, 64'h0, 4'h6, MAXP, 4'h6, 1);
        issue("jge_ovf",   0, SAOK, IJXX,    C_GE, 64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 0);
        issue("and",       0, SAOK, IOPQ,    4'h2, 64'hF0, 64'h3C, 64'h0, 4'h7, 64'h30, 4'h7, 1);
        issue("jne",       0, SAOK, IJXX,    C_NE, 64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);
        issue("irmovq",    0, SAOK, IIRMOVQ, 4'h0, 64'h0,  64'h999, 64'h55, 4'h1, 64'h55, 4'h1, 1);
        issue("rmmovq",    0, SAOK, IRMMOVQ, 4'h0, 64'h7,  64'h200, 64'h10, RNONE, 64'h210, RNONE, 1);
        issue("mrmovq",    0, SAOK, IMRMOVQ, 4'h0, 64'h0,  64'h300, 64'h8, RNONE, 64'h308, RNONE, 1);
        issue("pushq",     0, SAOK, IPUSHQ,  4'h0, 64'h42, 64'h100, 64'h0, RESP, 64'hF8,  RESP, 1);
        issue("popq",      0, SAOK, IPOPQ,   4'h0, 64'h0,  64'h100, 64'h0, RESP, 64'h108, RESP, 1);
        issue("call",      0, SAOK, ICALL,   4'h0, 64'h0,  64'h100, 64'h0, RESP, 64'hF8,  RESP, 1);
        issue("ret",       0, SAOK, IRET,    4'h0, 64'h0,  64'h100, 64'h0, RESP, 64'h108, RESP, 1);
        issue("jxx_bad",   0, SAOK, IJXX,    4'h7, 64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 0);
        issue("bubble",    1, SADR, IOPQ,    4'h1, 64'h1,  64'h2, 64'h0, 4'h3,  64'h0, RNONE, 1);
        issue("halt",      0, SHLT, IHALT,   4'h0, 64'h77, 64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);
        issue("sub_eq2",   0, SAOK, IOPQ,    4'h1, 64'h5,  64'h5, 64'h0, 4'h3,  64'h0, 4'h3, 0);
        issue("xor_gate",  0, SAOK, IOPQ,    4'h3, 64'h1,  64'h0, 64'h0, 4'h3,  64'h1, 4'h3, 1);
`ifdef EXEC_EXC_CC_GATE_EN
        issue("je_gated",  0, SAOK, IJXX,    C_E,  64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 1, SADR);
`else
        issue("je_ungated",0, SAOK, IJXX,    C_E,  64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 0, SADR);
`endif
        issue("add_2",     0, SAOK, IOPQ,    4'h0, 64'h1,  64'h1, 64'h0, 4'h3,  64'h2, 4'h3, 1);
        issue("jne_pre",   0, SAOK, IJXX,    C_NE, 64'h0,  64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);

        // Reset mid-cycle, away from any clock edge; state must clear immediately.
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        issue("je_after_rst", 0, SAOK, IJXX, C_E, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, RNONE, 1);

        repeat (3) @(negedge clk_i);
        if (exp_q.size() != 0) chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the Y86-64 five-stage pipeline. It owns the E pipeline register, which captures the decode stage's outputs on each clock. It also owns the ALU, the condition-code register and the branch/conditional-move evaluation. It feeds `e_valE_o`/`e_dstE_o` back to decode forwarding and hands the registered E-stage fields to the memory stage.

## Interface
- No parameters; all encodings come from the shared define file.
- `clk_i` in 1: single pipeline clock; all state updates on its rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `E_bubble_i` in 1: pipeline control; load a NOP bubble instead of decode outputs.
- `d_stat_i`, `d_icode_i`, `d_ifun_i` in 4 each: decode-stage status, icode, ifun.
- `d_valC_i`, `d_valA_i`, `d_valB_i` in 64 each: constant and forwarded operands.
- `d_dstE_i`, `d_dstM_i`, `d_srcA_i`, `d_srcB_i` in 4 each: register IDs from decode.
- `m_stat_i`, `W_stat_i` in 4 each: downstream status, used for condition-code gating.
- `e_valE_o` out 64: ALU result, combinational from the E register and CC.
- `e_dstE_o` out 4: destination for `e_valE_o`; `RNONE` when a cmov is not taken.
- `e_cnd_o` out 1: condition result for jXX/cmovXX.
- `E_stat_o`, `E_icode_o`, `E_dstM_o`, `E_srcA_o`, `E_srcB_o` out 4 each: registered fields for the memory stage and hazard control.
- `E_valA_o` out 64: registered valA for the memory stage.

## Operation
- **E register, reset or bubble:** load `stat=SAOK`, `icode=INOP`, `ifun=0`, all values 0, all register IDs `RNONE`.
- **E register, otherwise:** load every `d_*` input. Bubble has priority over a normal load.
- **aluA select:**
  - `valA` for RRMOVQ and OPQ.
  - `valC` for IRMOVQ, RMMOVQ and MRMOVQ.
  - −8 for CALL and PUSHQ.
  - +8 for RET and POPQ.
  - 0 for all other icodes.
- **aluB select:**
  - `valB` for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET and POPQ.
  - 0 for RRMOVQ and IRMOVQ.
- **ALU function:** `ifun` when icode is OPQ, else ADD. ADD = B+A, SUB = B−A, AND = B&A, XOR = B^A. All arithmetic is 64-bit, wrap-around, carry discarded.
- **Flags from the ALU result:** ZF = (result==0); SF = result[63].
  - OF for ADD: A and B have the same sign and the result sign differs.
  - OF for SUB: A and B have different signs and the result sign differs from B.
  - OF for AND/XOR: 0.
- **CC register {ZF,SF,OF}:**
  - Reset value is 3'b100.
  - Updated only when `set_cc` is true; `set_cc = (E_icode==OPQ)`, optionally gated (see Configuration).
- **Condition evaluation (`e_cnd_o`)** uses the current CC value, not the value being written this cycle. By `ifun`:
  - 0: 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): !ZF
  - 5 (ge): !(SF^OF)
  - 6 (g): !(SF^OF)&!ZF
  - ifun >6: 0
- **`e_dstE_o`:** `RNONE` if `E_icode==RRMOVQ && !e_cnd_o`, else `E_dstE`.

## Timing
- E register and CC register: 1-cycle latency from the `d_*` inputs to the `E_*` outputs.
- `e_valE_o`, `e_dstE_o`, `e_cnd_o` are combinational in the same cycle the instruction is in E, so decode can forward within that cycle.
- Output values during reset:
  - `E_stat_o = SAOK`, `E_icode_o = INOP`, `E_valA_o = 0`.
  - `E_dstM_o`, `E_srcA_o`, `E_srcB_o`, `e_dstE_o` = `RNONE`.
  - `e_valE_o = 0`, `e_cnd_o = 1` (ifun 0).
- Reset asserted mid-instruction discards the instruction and restores CC to 3'b100 immediately, without waiting for a clock edge.
- Back-to-back OPQ: the second instruction's `e_cnd_o` does not see the first's flags until the following cycle. A jXX directly after an OPQ sees the flags written at the edge that moved the jXX into E.

## Configuration
- `EXEC_EXC_CC_GATE_EN` defined: `set_cc` additionally requires `m_stat_i==SAOK` and `W_stat_i==SAOK`, so an instruction following a faulting one cannot change the CC.
- Not defined: `set_cc = (E_icode==OPQ)` only; `m_stat_i` and `W_stat_i` are ignored.

## Structure
- Shared define file: icodes, ALU function codes, condition codes (ifun), stat codes `SAOK`/`SADR`/`SINS`/`SHLT`, and `RNONE`/`RESP`.
- One sub-module, `exec_alu`: combinational, takes aluA, aluB and function; produces the 64-bit result and {ZF,SF,OF}.
- The CC register, condition evaluation and E register stay in `execute_stage`.

## Test plan
- Reset, then release with no bubble and decode driving a NOP: all outputs match the reset values in Timing and CC = 3'b100.
- OPQ SUB with valA=5, valB=5, dstE=3: `e_valE_o=0`, `e_dstE_o=3`; CC becomes ZF=1,SF=0,OF=0 at the next edge; a following jle has `e_cnd_o=1`.
- OPQ ADD with valA=valB=0x7FFF_FFFF_FFFF_FFFF: `e_valE_o=0xFFFF_FFFF_FFFF_FFFE`, and CC becomes SF=1, OF=1, ZF=0.
- cmovl (RRMOVQ, ifun=2) with CC SF=0,OF=0 and dstE=2: `e_cnd_o=0` and `e_dstE_o=RNONE`; with SF=1: `e_dstE_o=2` and `e_valE_o=valA`.
- PUSHQ with valB=0x100: `e_valE_o=0xF8` and `e_dstE_o=RESP`; POPQ with valB=0x100: `e_valE_o=0x108`.
- With `EXEC_EXC_CC_GATE_EN` defined, OPQ in E and `m_stat_i=SADR`: CC unchanged; with the macro undefined, the same stimulus updates CC.
